spi_fsm: RTL

Transaction controller for the SPI memory slave. It counts conditioned SCLK rising-edge pulses while chip select is low and decodes the read/write bit from the 8-bit shift register's parallel output. It sequences the strobes for the address latch, the data-memory write and the shift-register parallel load, and drives the MISO tri-state enable. It sits between the input conditioners (upstream) and the shift register, address latch and data memory (downstream).

---
 rtl/spi_fsm.sv | 122 ++++++++++++
 1 files changed

// File: rtl/spi_fsm.sv
// Transaction controller for the SPI memory slave: counts SCLK pulses while chip
// select is low, decodes read/write and sequences the latch, memory and load strobes.
module spi_fsm #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sclkPosEdge,
  input  logic csN,
  input  logic rwBit,
  output logic addrWe,
  output logic dmWe,
  output logic srWe,
  output logic misoBufe,
  output logic busy
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL      = CW'(WIDTH);
  localparam logic [CW-1:0] WAIT_LAST = CW'(READ_LATENCY - 1);

  typedef enum logic [3:0] {
    IDLE,
    GET_ADDR,
    GOT_ADDR,
    READ_WAIT,
    READ_LOAD,
    READ_SHIFT,
    WRITE_GET,
    WRITE_STORE,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_sat;

  assign cnt_sat = (cnt_q < FULL) ? cnt_q + 1'b1 : cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!csN) begin
          state_d = GET_ADDR;
          cnt_d   = '0;
        end
      end
      GET_ADDR: begin
        if (sclkPosEdge) begin
          cnt_d = cnt_sat;
          if (cnt_q == LAST_BIT) state_d = GOT_ADDR;
        end
      end
      GOT_ADDR: begin
        // The counter is reused to time the memory read latency.
        cnt_d   = '0;
        state_d = rwBit ? READ_WAIT : WRITE_GET;
      end
      READ_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = READ_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READ_LOAD: begin
        state_d = READ_SHIFT;
        cnt_d   = '0;
      end
      READ_SHIFT: begin
        if (sclkPosEdge) begin
          cnt_d = cnt_sat;
          if (cnt_q == LAST_BIT) state_d = DONE;
        end
      end
      WRITE_GET: begin
        if (sclkPosEdge) begin
          cnt_d = cnt_sat;
          if (cnt_q == LAST_BIT) state_d = WRITE_STORE;
        end
      end
      WRITE_STORE: state_d = DONE;
      DONE:        state_d = DONE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Chip-select release aborts from any state.
    if (csN) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Outputs are registered decodes of the next state, so they equal a Moore decode of state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addrWe   <= 1'b0;
      dmWe     <= 1'b0;
      srWe     <= 1'b0;
      misoBufe <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addrWe   <= (state_d == GOT_ADDR);
      dmWe     <= (state_d == WRITE_STORE);
      srWe     <= (state_d == READ_LOAD);
      misoBufe <= (state_d == READ_SHIFT);
      busy     <= (state_d != IDLE);
    end
  end

endmodule
